// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared shift-op encodings and shifter FSM states
//
// Purpose: encodings shared by the ALU, the decoder and seq_shifter.
//   SH_SLL / SH_SRL / SH_SRA are the 2-bit shift-type codes. 2'b11 is reserved
//   and is executed as SLL by the datapath.
//   state_t carries the seq_shifter FSM states S_IDLE / S_SHIFT / S_DONE.
// Ports: none (package).

package shift_pkg;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shifter_if.sv
// rtl/seq_shifter_if.sv - request/response bundle between EX-stage and seq_shifter
//
// Purpose: groups the shifter request and result signals.
// Ports (signals):
//   start   request, accepted only while busy==0
//   op      shift type (shift_pkg codes)
//   a       operand, sampled on accepted start
//   shamt   shift amount, $clog2(n) bits, sampled on accepted start
//   busy    high whenever the shifter is not idle
//   done    one-cycle result-valid pulse
//   result  shifted value, held until the next accepted start
// Modports: master = EX-stage stall logic, slave = seq_shifter.

interface seq_shifter_if #(
  parameter int n = 32
);

  localparam int sw = $clog2(n);

  logic          start;
  logic [1:0]    op;
  logic [n-1:0]  a;
  logic [sw-1:0] shamt;
  logic          busy;
  logic          done;
  logic [n-1:0]  result;

  modport master (
    output start, op, a, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, shamt,
    output busy, done, result
  );

endinterface

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit shift step
//
// Purpose: applies one bit of SLL, SRL or SRA to din, selected by op.
//   The reserved op 2'b11 behaves as SLL.
// Ports:
//   din   in   n   value before the step
//   op    in   2   shift type (shift_pkg codes)
//   dout  out  n   value after the step

module shift_step
  import shift_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [n-1:0] din,
  input  logic [1:0]   op,
  output logic [n-1:0] dout
);

  always_comb begin
    dout = {din[n-2:0], 1'b0};
    case (op)
      SH_SLL:  dout = {din[n-2:0], 1'b0};
      SH_SRL:  dout = {1'b0, din[n-1:1]};
      SH_SRA:  dout = {din[n-1], din[n-1:1]};
      default: dout = {din[n-2:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle SLL/SRL/SRA unit iterating a one-bit step
//
// Purpose: replaces the ALU barrel shifter. An accepted start loads the operand,
//   op and shift amount; the FSM then shifts one bit per clock and pulses done
//   for one cycle when the result is ready.
//   Optional: define SEQ_SHIFT_STEP4_EN to shift four bits per clock while at
//   least four bits remain (latency floor(shamt/4) + shamt%4 + 1). Ports are
//   the same in both builds.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset, overrides everything
//   bus   slave modport of seq_shifter_if (start/op/a/shamt in,
//         busy/done/result out); its n must match this module's n.

module seq_shifter
  import shift_pkg::*;
#(
  parameter int n = 32
) (
  input  logic          clk,
  input  logic          rst,
  seq_shifter_if.slave  bus
);

  localparam int sw = $clog2(n);

  state_t        state_q, state_d;
  logic [sw-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [n-1:0]  res_q, res_d;
  logic [n-1:0]  step1;

  shift_step #(.n(n)) u_step1 (.din(res_q), .op(op_q), .dout(step1));

`ifdef SEQ_SHIFT_STEP4_EN
  logic [n-1:0] step2, step3, step4;

  shift_step #(.n(n)) u_step2 (.din(step1), .op(op_q), .dout(step2));
  shift_step #(.n(n)) u_step3 (.din(step2), .op(op_q), .dout(step3));
  shift_step #(.n(n)) u_step4 (.din(step3), .op(op_q), .dout(step4));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= SH_SLL;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          res_d   = bus.a;
          op_d    = bus.op;
          cnt_d   = bus.shamt;
          state_d = (bus.shamt != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
`ifdef SEQ_SHIFT_STEP4_EN
        if (cnt_q >= sw'(4)) begin
          res_d = step4;
          cnt_d = cnt_q - sw'(4);
        end else begin
          res_d = step1;
          cnt_d = cnt_q - sw'(1);
        end
`else
        res_d = step1;
        cnt_d = cnt_q - sw'(1);
`endif
        // Leave as the count reaches zero, so cnt is never decremented below 0.
        if (cnt_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = res_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - directed and random self-checking bench for seq_shifter

module tb_seq_shifter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_shifter_if #(.n(32)) bus ();

  seq_shifter #(.n(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input int s);
`ifdef SEQ_SHIFT_STEP4_EN
    return s / 4 + s % 4 + 1;
`else
    return s + 1;
`endif
  endfunction

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                            input int s);
    case (op)
      2'b01:   return a >> s;
      2'b10:   return $unsigned($signed(a) >>> s);
      default: return a << s;
    endcase
  endfunction

  // Called at a negedge with the shifter idle; returns at the negedge after done.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [4:0] s,
                       output logic [31:0] res, output int lat);
    bus.op    = op;
    bus.a     = a;
    bus.shamt = s;
    bus.start = 1'b1;
    lat = -1;
    res = '0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.op    = op ^ 2'b11;
        bus.shamt = ~s;
      end
      if (bus.done) begin
        lat = c;
        res = bus.result;
        break;
      end
    end
    @(negedge clk);
    chk("done_once", 32'(bus.done), 32'd0);
    chk("idle_after", 32'(bus.busy), 32'd0);
    chk("result_held", bus.result, res);
  endtask

  logic [31:0] res;
  int          lat;
  int          ndone;
  logic [1:0]  rop;
  logic [31:0] ra;
  logic [4:0]  rs;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.shamt = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1. SLL 1 by 31
    do_op(2'b00, 32'h0000_0001, 5'd31, res, lat);
    chk("t1_res", res, 32'h8000_0000);
    chk("t1_lat", 32'(lat), 32'(exp_lat(31)));
`ifdef SEQ_SHIFT_STEP4_EN
    chk("t6_lat", 32'(lat), 32'd11);
`else
    chk("t1_lat32", 32'(lat), 32'd32);
`endif

    // 2. SRA / SRL of 0x8000_0000 by 4
    do_op(2'b10, 32'h8000_0000, 5'd4, res, lat);
    chk("t2_sra", res, 32'hF800_0000);
    chk("t2_lat", 32'(lat), 32'(exp_lat(4)));
    do_op(2'b01, 32'h8000_0000, 5'd4, res, lat);
    chk("t2_srl", res, 32'h0800_0000);

    // Reserved op behaves as SLL
    do_op(2'b11, 32'h0000_00F0, 5'd4, res, lat);
    chk("rsv_res", res, 32'h0000_0F00);

    // 3. shamt=0 for every op
    for (int o = 0; o < 4; o++) begin
      do_op(2'(o), 32'hDEAD_BEEF, 5'd0, res, lat);
      chk("t3_res", res, 32'hDEAD_BEEF);
      chk("t3_lat", 32'(lat), 32'd1);
    end

    // 4. second start in cycle 2 is ignored
    bus.op = 2'b00; bus.a = 32'h0000_0003; bus.shamt = 5'd8; bus.start = 1'b1;
    ndone = 0; lat = -1; res = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.start = (c == 2);
      if (c == 2) begin
        bus.a = 32'h1234_5678; bus.shamt = 5'd1; bus.op = 2'b01;
      end
      if (bus.done) begin
        ndone++;
        if (lat < 0) begin lat = c; res = bus.result; end
      end
    end
    bus.start = 1'b0;
    chk("t4_ndone", 32'(ndone), 32'd1);
    chk("t4_res", res, 32'h0000_0300);
    chk("t4_lat", 32'(lat), 32'(exp_lat(8)));

    // start in the done cycle is ignored
    bus.op = 2'b00; bus.a = 32'h0000_0005; bus.shamt = 5'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 2; c <= 20 && !bus.done; c++) @(negedge clk);
    chk("td_done", 32'(bus.done), 32'd1);
    bus.a = 32'hFFFF_FFFF; bus.shamt = 5'd0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("td_busy", 32'(bus.busy), 32'd0);
    chk("td_res", bus.result, 32'h0000_0014);

    // 5. reset mid-operation
    bus.op = 2'b00; bus.a = 32'h0000_0001; bus.shamt = 5'd10; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_done", 32'(bus.done), 32'd0);
    chk("t5_res", bus.result, 32'd0);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("t5_nodone", 32'(ndone), 32'd0);
    do_op(2'b01, 32'hF000_0000, 5'd12, res, lat);
    chk("t5_fresh", res, 32'h000F_0000);
    chk("t5_lat", 32'(lat), 32'(exp_lat(12)));

    // 6. random ops against the reference model
    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rs  = 5'($urandom_range(0, 31));
      do_op(rop, ra, rs, res, lat);
      chk("rnd_res", res, ref_shift(rop, ra, int'(rs)));
      chk("rnd_lat", 32'(lat), 32'(exp_lat(int'(rs))));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
